// File: rtl/led_fader_if.sv
// Control/status bundle between the clock divider side and the LED fade sequencer.
// The divider side drives cnt/enable; the fader returns PWM drive and status.
interface led_fader_if;
    logic [2:0] cnt;
    logic       enable;
    logic [2:0] rgb;
    logic       step;
    logic [1:0] phase;

    modport master (output cnt, enable, input rgb, step, phase);
    modport slave  (input cnt, enable, output rgb, step, phase);
endinterface

// File: rtl/led_fader.sv
// LED fade sequencer: each change of the divider count is one fade step; the duty
// ramps up, holds and ramps down on one RGB channel at a time, rotating R->G->B.

// One PWM channel: registered compare of the shared counter against the duty.
module led_fader_chan #(
    parameter int PWM_BITS = 8,
    parameter int IDX      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active,
    input  logic [1:0]          colour,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= 1'b0;
        else        led <= active && (colour == 2'(IDX)) && (pwm_cnt < duty);
    end
endmodule

module led_fader #(
    parameter int PWM_BITS   = 8,
    parameter int FADE_STEP  = 16,
    parameter int HOLD_STEPS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    led_fader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RISE = 2'b01,
        HOLD = 2'b10,
        FALL = 2'b11
    } state_t;

    localparam int HW = (HOLD_STEPS < 1) ? 1 : $clog2(HOLD_STEPS + 1);
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [HW-1:0]       HOLD_END = HW'(HOLD_STEPS);

    state_t              state, state_n;
    logic [2:0]          cnt_q;
    logic                step;
    logic [PWM_BITS-1:0] duty, duty_n;
    logic [1:0]          colour, colour_n;
    logic [HW-1:0]       hold_cnt, hold_n;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          rgb_q;
    logic                active;

    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS-1:0] rise_duty, fall_duty;
    logic [HW-1:0]       hold_inc;

    // Any difference from last cycle's count is one step, whatever the jump size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            step  <= 1'b0;
        end else begin
            cnt_q <= bus.cnt;
            step  <= bus.enable && (bus.cnt != cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= '0;
            colour   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            colour   <= colour_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        // Sum is one bit wider so the saturation at MAX never sees a wrapped value.
        sum       = {1'b0, duty} + STEP_X;
        rise_duty = (sum > {1'b0, MAX}) ? MAX : sum[PWM_BITS-1:0];
        fall_duty = ({1'b0, duty} > STEP_X) ? (duty - STEP_X[PWM_BITS-1:0]) : '0;
        hold_inc  = hold_cnt + 1'b1;

        state_n  = state;
        duty_n   = duty;
        colour_n = colour;
        hold_n   = hold_cnt;

        if (!bus.enable) begin
            state_n  = IDLE;
            duty_n   = '0;
            colour_n = '0;
            hold_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = RISE;
                    duty_n   = '0;
                    colour_n = '0;
                    hold_n   = '0;
                end
                RISE: if (step) begin
                    duty_n = rise_duty;
                    if (rise_duty == MAX) begin
                        state_n = HOLD;
                        hold_n  = '0;
                    end
                end
                HOLD: if (step) begin
                    hold_n = hold_inc;
                    if (hold_inc == HOLD_END) state_n = FALL;
                end
                FALL: if (step) begin
                    duty_n = fall_duty;
                    if (fall_duty == '0) begin
                        state_n  = RISE;
                        colour_n = (colour == 2'd2) ? 2'd0 : colour + 2'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign active = (state != IDLE);

    for (genvar g = 0; g < 3; g++) begin : g_chan
        led_fader_chan #(.PWM_BITS(PWM_BITS), .IDX(g)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .active  (active),
            .colour  (colour),
            .pwm_cnt (pwm_cnt),
            .duty    (duty),
            .led     (rgb_q[g])
        );
    end

    assign bus.rgb   = rgb_q;
    assign bus.step  = step;
    assign bus.phase = state;
endmodule
